// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder: one full-adder cell per bit, purely combinational.
module nibble_serial_adder_rca
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands through one 4-bit adder, LSB nibble first.
// Result registers update only on the final nibble, so partial sums are never visible.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]    r_a_sh;
  logic [WIDTH-1:0]    r_b_sh;
  logic [WIDTH-1:0]    r_s_sh;
  logic                r_cy;
  logic [IDX_W-1:0]    r_idx;
  logic [WIDTH-1:0]    r_sum;
  logic                r_c_out;

  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;
  logic                w_accept;
  logic                w_last;

  nibble_serial_adder_rca u_rca (
    .a     (r_a_sh[NIBBLE_W-1:0]),
    .b     (r_b_sh[NIBBLE_W-1:0]),
    .c_in  (r_cy),
    .sum   (w_nib_sum),
    .c_out (w_nib_cout)
  );

  // New work is taken from IDLE or DONE; start during RUN is dropped.
  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_idx == IDX_W'(NIB - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_cy    <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sh <= a;
        r_b_sh <= b;
        r_cy   <= c_in;
        r_idx  <= '0;
      end else if (r_state == ST_RUN) begin
        r_a_sh <= r_a_sh >> NIBBLE_W;
        r_b_sh <= r_b_sh >> NIBBLE_W;
        r_s_sh <= {w_nib_sum, r_s_sh[WIDTH-1:NIBBLE_W]};
        r_cy   <= w_nib_cout;
        r_idx  <= r_idx + IDX_W'(1);
      end
      // The final nibble goes straight into the result alongside the shifted history.
      if (w_last) begin
        r_sum   <= {w_nib_sum, r_s_sh[WIDTH-1:NIBBLE_W]};
        r_c_out <= w_nib_cout;
      end
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised and directed checks of the nibble-serial adder against plain a+b+c_in arithmetic.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int n_checks = 0;
  int n_errors = 0;

  // Last result the outputs are expected to hold: {c_out, sum}.
  logic [WIDTH:0] model;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Drive a request at the current negedge; returns at the negedge after the accept edge.
  task automatic start_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    a     = ta;
    b     = tb_v;
    c_in  = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk the RUN cycles up to the done pulse, optionally disturbing inputs on the way.
  task automatic wait_result(input string tag, input logic [WIDTH:0] exp,
                             input int glitch_k, input bit scramble);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      check({tag, "_busy"}, 64'(busy), 64'(1'b1));
      check({tag, "_hold"}, 64'({c_out, sum}), 64'(model));
      if (scramble) begin
        a    = WIDTH'($urandom);
        b    = WIDTH'($urandom);
        c_in = 1'($urandom);
      end
      if (k == glitch_k) begin
        start = 1'b1;
        a     = 16'h5555;
        b     = 16'h5555;
        c_in  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_lat"},    64'(k),    64'(NIB));
    check({tag, "_done"},   64'(done), 64'(1'b1));
    check({tag, "_busyoff"},64'(busy), 64'(1'b0));
    check({tag, "_result"}, 64'({c_out, sum}), 64'(exp));
    model = exp;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'(1'b0));
    check({tag, "_idle"},  64'(busy), 64'(1'b0));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    // Reset with start held high: start must be ignored.
    reset = 1'b1;
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    c_in  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(busy),  64'(1'b0));
    check("rst_done",  64'(done),  64'(1'b0));
    check("rst_sum",   64'(sum),   64'(16'h0000));
    check("rst_cout",  64'(c_out), 64'(1'b0));
    reset = 1'b0;
    start = 1'b0;
    model = '0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(1'b0));

    start_add(16'h0000, 16'h0000, 1'b1);
    wait_result("t2", 17'h00001, -1, 1'b0);
    expect_idle("t2");

    start_add(16'hFFFF, 16'h0001, 1'b0);
    wait_result("t3", 17'h10000, -1, 1'b0);
    expect_idle("t3");

    // Second request issued in the DONE cycle of the first.
    start_add(16'h1234, 16'h8765, 1'b1);
    wait_result("t4", 17'h0999A, -1, 1'b0);
    start_add(16'hFFFF, 16'hFFFF, 1'b1);
    wait_result("t4b", 17'h1FFFF, -1, 1'b0);
    expect_idle("t4b");

    start_add(16'h00FF, 16'h0001, 1'b0);
    wait_result("t5", 17'h00100, 2, 1'b0);
    expect_idle("t5");

    // Reset in RUN cycle 2 discards the add.
    start_add(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_pre", 64'(busy), 64'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model = '0;
    check("t6_busy", 64'(busy),  64'(1'b0));
    check("t6_done", 64'(done),  64'(1'b0));
    check("t6_sum",  64'(sum),   64'(16'h0000));
    check("t6_cout", 64'(c_out), 64'(1'b0));
    repeat (3) begin
      @(negedge clk);
      check("t6_nodone", 64'(done), 64'(1'b0));
    end
    start_add(16'h0003, 16'h0004, 1'b0);
    wait_result("t6b", 17'h00007, -1, 1'b0);
    expect_idle("t6b");

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      if (i % 8 == 0) begin
        ra = 16'hFFFF;
        rb = WIDTH'($urandom_range(0, 1));
      end
      start_add(ra, rb, rc);
      wait_result("rnd", ref_add(ra, rb, rc), int'($urandom_range(0, 5)), 1'b1);
      if ($urandom_range(0, 1) == 1) expect_idle("rnd");
    end
    expect_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
